// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU constants for the pipeline controller: register/op widths, mul/div op codes, FSM states.
// No logic here beyond a small op-class helper.
package pipe_ctrl_pkg;

    localparam int CPU_REGNO_WIDTH = 5;
    localparam int CPU_IMDOP_WIDTH = 4;
    localparam int BUSY_CNT_WIDTH  = 6;
    localparam int FLUSH_CNT_WIDTH = 2;

    typedef enum logic [CPU_IMDOP_WIDTH-1:0] {
        CPU_IMDOP_IDLE = 4'd0,
        CPU_IMDOP_MUL  = 4'd1,
        CPU_IMDOP_MULU = 4'd2,
        CPU_IMDOP_DIV  = 4'd3,
        CPU_IMDOP_DIVU = 4'd4,
        CPU_IMDOP_MFHI = 4'd5,
        CPU_IMDOP_MFLO = 4'd6,
        CPU_IMDOP_MTHI = 4'd7,
        CPU_IMDOP_MTLO = 4'd8
    } imdop_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_e;

    // Ops that occupy the mul/div unit for several cycles (HI/LO moves do not).
    function automatic logic is_long_op(input logic [CPU_IMDOP_WIDTH-1:0] op);
        return (op == CPU_IMDOP_MUL) || (op == CPU_IMDOP_MULU) ||
               (op == CPU_IMDOP_DIV) || (op == CPU_IMDOP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [CPU_IMDOP_WIDTH-1:0] op);
        return (op == CPU_IMDOP_DIV) || (op == CPU_IMDOP_DIVU);
    endfunction

endpackage

// File: rtl/pipe_ctrl_imd_busy_cnt.sv
// Purpose: mul/div unit busy down-counter, loaded on issue, busy while non-zero.
// Latency: busy rises the cycle after load and stays high for load_val cycles.
// Backpressure: none; counts down every cycle regardless of pipeline stalls.
module pipe_ctrl_imd_busy_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      load,
    input  logic [BUSY_CNT_WIDTH-1:0] load_val,
    output logic                      busy
);

    logic [BUSY_CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline hazard/flush controller (load-use, mul/div busy, exception flush).
// Latency: stall/bubble combinational from decode/execute info; drop starts the cycle after i_exc.
// Backpressure: external stalls freeze decode without bubbling; flush overrides all stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 34,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [CPU_REGNO_WIDTH-1:0] i_dec_rs_no,
    input  logic [CPU_REGNO_WIDTH-1:0] i_dec_rt_no,
    input  logic [CPU_IMDOP_WIDTH-1:0] i_dec_imuldiv_op,
    input  logic [CPU_REGNO_WIDTH-1:0] i_ex_rd_no,
    input  logic                       i_ex_load,
    input  logic                       i_exc,
    input  logic                       i_fetch_stall,
    input  logic                       i_mem_stall,
    output logic                       o_dec_stall,
    output logic                       o_ex_bubble,
    output logic                       o_drop,
    output logic                       o_imd_busy
);

    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_RELOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [BUSY_CNT_WIDTH-1:0]  MUL_LOAD     = BUSY_CNT_WIDTH'(MUL_CYCLES);
    localparam logic [BUSY_CNT_WIDTH-1:0]  DIV_LOAD     = BUSY_CNT_WIDTH'(DIV_CYCLES);

    pipe_state_e                state, state_nxt;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt, flush_cnt_nxt;

    logic ext_stall;
    logic load_use;
    logic md_hazard;
    logic issue;
    logic [BUSY_CNT_WIDTH-1:0] busy_load_val;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign ext_stall = i_fetch_stall | i_mem_stall;
    assign load_use  = i_ex_load && (i_ex_rd_no != '0) &&
                       ((i_ex_rd_no == i_dec_rs_no) || (i_ex_rd_no == i_dec_rt_no));
    assign md_hazard = o_imd_busy && (i_dec_imuldiv_op != CPU_IMDOP_IDLE);

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        o_dec_stall   = 1'b0;
        o_ex_bubble   = 1'b0;
        o_drop        = 1'b0;
        issue         = 1'b0;

        case (state)
            ST_RUN: begin
                if (i_exc) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = FLUSH_RELOAD;
                end
                if (ext_stall) begin
                    o_dec_stall = 1'b1;
                end else if (load_use || md_hazard) begin
                    o_dec_stall = 1'b1;
                    o_ex_bubble = 1'b1;
                end else begin
                    issue = is_long_op(i_dec_imuldiv_op);
                end
            end
            ST_FLUSH: begin
                // A fresh exception restarts the flush window rather than stacking.
                o_drop      = 1'b1;
                o_ex_bubble = 1'b1;
                if (i_exc) begin
                    flush_cnt_nxt = FLUSH_RELOAD;
                end else if (flush_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_RUN;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    assign busy_load_val = is_div_op(i_dec_imuldiv_op) ? DIV_LOAD : MUL_LOAD;

    pipe_ctrl_imd_busy_cnt u_busy_cnt (
        .clk      (clk),
        .nrst     (nrst),
        .load     (issue),
        .load_val (busy_load_val),
        .busy     (o_imd_busy)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed cycle table with hand-derived expectations, then random traffic
// against a remaining-cycles reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MULC = 4;
    localparam int DIVC = 34;
    localparam int FLC  = 2;

    logic       clk = 1'b0;
    logic       nrst;
    logic [4:0] rs, rt, rd;
    logic [3:0] op;
    logic       ld, exc, fs, ms;
    logic       o_dec_stall, o_ex_bubble, o_drop, o_imd_busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .FLUSH_CYCLES(FLC)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .i_dec_rs_no      (rs),
        .i_dec_rt_no      (rt),
        .i_dec_imuldiv_op (op),
        .i_ex_rd_no       (rd),
        .i_ex_load        (ld),
        .i_exc            (exc),
        .i_fetch_stall    (fs),
        .i_mem_stall      (ms),
        .o_dec_stall      (o_dec_stall),
        .o_ex_bubble      (o_ex_bubble),
        .o_drop           (o_drop),
        .o_imd_busy       (o_imd_busy)
    );

    typedef struct {
        logic       n;
        logic [4:0] rs, rt, rd;
        logic [3:0] op;
        logic       ld, exc, fs, ms;
        logic [3:0] exp; // {stall, bubble, drop, busy}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic n, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic [3:0] a_op, input logic [4:0] a_rd, input logic a_ld,
                       input logic a_exc, input logic a_fs, input logic a_ms,
                       input logic [3:0] a_exp);
        vec_t v;
        v.n = n; v.rs = a_rs; v.rt = a_rt; v.op = a_op; v.rd = a_rd;
        v.ld = a_ld; v.exc = a_exc; v.fs = a_fs; v.ms = a_ms; v.exp = a_exp;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        nrst = v.n; rs = v.rs; rt = v.rt; op = v.op; rd = v.rd;
        ld = v.ld; exc = v.exc; fs = v.fs; ms = v.ms;
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s @%0d: got %0b, expected %0b", name, idx, act, exp);
        else
            passed++;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] exp);
        chk({tag, ".dec_stall"}, idx, o_dec_stall, exp[3]);
        chk({tag, ".ex_bubble"}, idx, o_ex_bubble, exp[2]);
        chk({tag, ".drop"},      idx, o_drop,      exp[1]);
        chk({tag, ".imd_busy"},  idx, o_imd_busy,  exp[0]);
    endtask

    // Reference model: cycles of drop and busy still owed.
    int fl_left, bl_left;

    function automatic logic [3:0] model_out(input vec_t v);
        logic drop, busy, luh, mdh;
        drop = fl_left > 0;
        busy = bl_left > 0;
        luh  = v.ld && v.rd != 0 && (v.rd == v.rs || v.rd == v.rt);
        mdh  = busy && v.op != 0;
        if (drop)              return {2'b01, drop, busy};
        else if (v.fs || v.ms) return {2'b10, drop, busy};
        else if (luh || mdh)   return {2'b11, drop, busy};
        else                   return {2'b00, drop, busy};
    endfunction

    task automatic model_step(input vec_t v);
        logic drop, luh, mdh, iss;
        drop = fl_left > 0;
        luh  = v.ld && v.rd != 0 && (v.rd == v.rs || v.rd == v.rt);
        mdh  = (bl_left > 0) && v.op != 0;
        iss  = !drop && !(v.fs || v.ms) && !luh && !mdh && v.op >= 1 && v.op <= 4;
        if (!v.n) begin
            fl_left = 0;
            bl_left = 0;
        end else begin
            if (v.exc)            fl_left = FLC;
            else if (fl_left > 0) fl_left--;
            if (iss)              bl_left = (v.op <= 2) ? MULC : DIVC;
            else if (bl_left > 0) bl_left--;
        end
    endtask

    initial begin
        vec_t v;
        nrst = 1'b0; rs = '0; rt = '0; rd = '0; op = '0;
        ld = 1'b0; exc = 1'b0; fs = 1'b0; ms = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // n  rs rt op              rd ld exc fs ms  {stall,bub,drop,busy}
        add(0, 5, 0, CPU_IMDOP_IDLE, 5, 1, 0, 0, 0, 4'b1100); // hazards visible during reset
        add(1, 5, 0, CPU_IMDOP_IDLE, 5, 1, 0, 0, 0, 4'b1100); // load-use on rs
        add(1, 5, 0, CPU_IMDOP_IDLE, 0, 1, 0, 0, 0, 4'b0000); // rd=0 never hazards
        add(1, 0, 7, CPU_IMDOP_IDLE, 7, 1, 0, 0, 0, 4'b1100); // load-use on rt
        add(1, 5, 0, CPU_IMDOP_IDLE, 5, 0, 0, 0, 0, 4'b0000); // not a load
        add(1, 5, 0, CPU_IMDOP_IDLE, 5, 1, 0, 0, 1, 4'b1000); // mem stall beats load-use
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 1, 0, 4'b1000); // fetch stall
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 1, 0, 0, 4'b0000); // exception sampled
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0110); // flush 1
        add(1, 5, 0, CPU_IMDOP_IDLE, 5, 1, 0, 0, 1, 4'b0110); // flush 2 beats everything
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000); // back to run
        add(1, 0, 0, CPU_IMDOP_MUL,  0, 0, 0, 0, 0, 4'b0000); // MULT issues
        for (int k = 0; k < MULC; k++)
            add(1, 0, 0, CPU_IMDOP_MFLO, 0, 0, 0, 0, 0, 4'b1101); // MFLO waits on busy
        add(1, 0, 0, CPU_IMDOP_MFLO, 0, 0, 0, 0, 0, 4'b0000); // MFLO goes
        add(1, 0, 0, CPU_IMDOP_MFLO, 0, 0, 0, 0, 0, 4'b0000); // MFLO does not load busy
        add(1, 0, 0, CPU_IMDOP_MUL,  0, 0, 0, 0, 1, 4'b1000); // stalled MULT not issued
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000);
        add(1, 0, 0, CPU_IMDOP_MULU, 0, 0, 1, 0, 0, 4'b0000); // MULTU issues with exception
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0111);
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 1, 0, 0, 4'b0111); // second exception in flush
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0111); // extended flush 1
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0111); // extended flush 2
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000);
        add(1, 0, 0, CPU_IMDOP_DIV,  0, 0, 0, 0, 0, 4'b0000); // DIV issues at cycle 0
        for (int k = 1; k < 10; k++)
            add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0001);
        add(0, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0001); // reset at cycle 10
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000); // busy aborted
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 1, 0, 0, 4'b0000);
        add(0, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0110); // reset mid-flush
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000); // flush aborted
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 1, 0, 0, 4'b0000);
        add(1, 0, 0, CPU_IMDOP_DIV,  0, 0, 0, 0, 0, 4'b0110); // no issue in flush
        add(1, 0, 0, CPU_IMDOP_DIVU, 0, 0, 0, 0, 0, 4'b0110);
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000);
        add(1, 0, 0, CPU_IMDOP_IDLE, 0, 0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk_all("vec", i, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Random traffic against the model, starting from a clean reset.
        v = tbl[0];
        v.n = 1'b0; v.ld = 1'b0; v.exc = 1'b0; v.fs = 1'b0; v.ms = 1'b0; v.op = '0;
        drive(v);
        @(posedge clk);
        #1;
        fl_left = 0;
        bl_left = 0;
        for (int i = 0; i < 4000; i++) begin
            v.n   = ($urandom_range(0, 199) != 0);
            v.rs  = 5'($urandom_range(0, 3));
            v.rt  = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.ld  = 1'($urandom_range(0, 1));
            v.op  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
            v.exc = ($urandom_range(0, 15) == 0);
            v.fs  = ($urandom_range(0, 9) == 0);
            v.ms  = ($urandom_range(0, 9) == 0);
            drive(v);
            @(negedge clk);
            chk_all("rnd", i, model_out(v));
            model_step(v);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
